// File: rtl/screen_access_arbiter.sv
// Round-robin arbiter sharing the SDRAM pixel read-modify-write port
// among N drawing engines; holds each grant until the interface is done.
module screen_access_arbiter #(
  parameter int N        = 2,
  parameter int COORD_W  = 16,
  parameter int COLOUR_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N-1:0]          req_start,
  input  logic [N*COORD_W-1:0]  req_x_min,
  input  logic [N*COORD_W-1:0]  req_y_min,
  input  logic [N*COORD_W-1:0]  req_x_range,
  input  logic [N*COORD_W-1:0]  req_y_range,
  input  logic [N*COLOUR_W-1:0] req_new_colour,
  output logic [N-1:0]          req_done,
  output logic [COORD_W-1:0]    req_x,
  output logic [COORD_W-1:0]    req_y,
  output logic [COLOUR_W-1:0]   req_old_colour,
  output logic [N-1:0]          grant,
  output logic                  busy,
  output logic                  screen_start,
  output logic [COORD_W-1:0]    screen_x_min,
  output logic [COORD_W-1:0]    screen_y_min,
  output logic [COORD_W-1:0]    screen_x_range,
  output logic [COORD_W-1:0]    screen_y_range,
  output logic [COLOUR_W-1:0]   new_screen_colour,
  input  logic [COORD_W-1:0]    screen_x,
  input  logic [COORD_W-1:0]    screen_y,
  input  logic [COLOUR_W-1:0]   old_screen_colour,
  input  logic                  screen_done
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RELEASE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [N-1:0]        r_grant;
  logic [IW-1:0]       r_rr_ptr;
  logic [IW-1:0]       r_idx;
  logic                r_start;
  logic [COORD_W-1:0]  r_x_min;
  logic [COORD_W-1:0]  r_y_min;
  logic [COORD_W-1:0]  r_x_range;
  logic [COORD_W-1:0]  r_y_range;

  logic [N-1:0]        w_rot;
  logic [IW-1:0]       w_pos;
  logic [IW:0]         w_sum;
  logic [IW-1:0]       w_win;
  logic [IW:0]         w_inc;
  logic [IW-1:0]       w_ptr_nxt;
  logic                w_any;
  logic [COORD_W-1:0]  w_x_min;
  logic [COORD_W-1:0]  w_y_min;
  logic [COORD_W-1:0]  w_x_range;
  logic [COORD_W-1:0]  w_y_range;
  logic [COLOUR_W-1:0] w_colour;

  assign w_any = |req_start;

  // Rotate requests so bit 0 is the requester at rr_ptr.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < N; i++) begin
      for (int p = 0; p < N; p++) begin
        if (r_rr_ptr == IW'(p)) w_rot[i] = req_start[(i + p) % N];
      end
    end
  end

  always_comb begin
    w_pos = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_pos = IW'(i);
    end
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_pos};
    if (w_sum >= (IW+1)'(N)) w_sum = w_sum - (IW+1)'(N);
    w_win = w_sum[IW-1:0];
  end

  always_comb begin
    w_inc = {1'b0, r_idx} + (IW+1)'(1);
    if (w_inc >= (IW+1)'(N)) w_inc = '0;
    w_ptr_nxt = w_inc[IW-1:0];
  end

  always_comb begin
    w_x_min   = '0;
    w_y_min   = '0;
    w_x_range = '0;
    w_y_range = '0;
    for (int i = 0; i < N; i++) begin
      if (w_win == IW'(i)) begin
        w_x_min   = req_x_min[i*COORD_W +: COORD_W];
        w_y_min   = req_y_min[i*COORD_W +: COORD_W];
        w_x_range = req_x_range[i*COORD_W +: COORD_W];
        w_y_range = req_y_range[i*COORD_W +: COORD_W];
      end
    end
  end

  // Grant is one-hot or zero, so an OR of masked slices is the mux.
  always_comb begin
    w_colour = '0;
    for (int i = 0; i < N; i++) begin
      if (r_grant[i]) w_colour = w_colour | req_new_colour[i*COLOUR_W +: COLOUR_W];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_any) w_state_nxt = S_GRANT;
      S_GRANT:   if (screen_done) w_state_nxt = S_RELEASE;
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_grant   <= '0;
      r_rr_ptr  <= '0;
      r_idx     <= '0;
      r_start   <= 1'b0;
      r_x_min   <= '0;
      r_y_min   <= '0;
      r_x_range <= '0;
      r_y_range <= '0;
    end else if (r_state == S_IDLE && w_any) begin
      r_grant   <= N'(1) << w_win;
      r_idx     <= w_win;
      r_start   <= 1'b1;
      r_x_min   <= w_x_min;
      r_y_min   <= w_y_min;
      r_x_range <= w_x_range;
      r_y_range <= w_y_range;
    end else if (r_state == S_GRANT && screen_done) begin
      r_grant  <= '0;
      r_start  <= 1'b0;
      r_rr_ptr <= w_ptr_nxt;
    end
  end

  assign grant             = r_grant;
  assign busy              = (r_state != S_IDLE);
  assign screen_start      = r_start;
  assign screen_x_min      = r_x_min;
  assign screen_y_min      = r_y_min;
  assign screen_x_range    = r_x_range;
  assign screen_y_range    = r_y_range;
  assign new_screen_colour = w_colour;
  assign req_done          = {N{screen_done}} & r_grant;
  assign req_x             = screen_x;
  assign req_y             = screen_y;
  assign req_old_colour    = old_screen_colour;

endmodule
